// File: rtl/osd_blend.sv
`default_nettype none
// ============================================================================
//  Module      : osd_blend
//  Description : Alpha-blends a CLUT-coded on-screen-display layer over a
//                YUV video stream. Three-stage pipeline: S1 registers inputs
//                and reads the CLUT, S2 forms products, S3 sums, rounds and
//                registers outputs. Syncs and pixel_en are delayed unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_blend #(
    parameter int CLUT_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  y_in,
    input  logic [7:0]  u_in,
    input  logic [7:0]  v_in,
    input  logic [7:0]  osd_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        pixel_en_in,
    input  logic        osd_enable,
    input  logic        clut_wr_en,
    input  logic [3:0]  clut_wr_addr,
    input  logic [28:0] clut_wr_dat,
    output logic [7:0]  y_out,
    output logic [7:0]  u_out,
    output logic [7:0]  v_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        pixel_en_out
);

    // Pixel/sync pipeline depth; fixed by the stage structure below.
    localparam int       LATENCY    = 3;
    localparam logic [7:0] c_BLACK_Y  = 8'd16;
    localparam logic [7:0] c_BLACK_C  = 8'd128;
    localparam logic [4:0] c_ALPHA_MAX = 5'd16;

    logic [28:0] r_clut [CLUT_DEPTH];
    logic        r_vs_prev;
    logic        r_osd_active;

    // S1 registers
    logic [7:0]  r_s1_py, r_s1_pu, r_s1_pv;
    logic [7:0]  r_s1_cy, r_s1_cu, r_s1_cv;
    logic [4:0]  r_s1_a;

    // S2 registers: overlay and video products per component
    logic [12:0] r_s2_cy, r_s2_cu, r_s2_cv;
    logic [12:0] r_s2_py, r_s2_pu, r_s2_pv;

    // Sync/active-video delay line, packed as {h_sync, v_sync, pixel_en}
    logic [2:0]  r_sync [LATENCY];

    logic [7:0]  r_y_out, r_u_out, r_v_out;

    logic [3:0]  w_idx;
    logic [28:0] w_entry;
    logic        w_blend;
    logic [4:0]  w_alpha;
    logic [4:0]  w_inv_a;

    // S1 CLUT read and blend decision; entry 0 is always transparent.
    always_comb begin
        w_idx   = osd_in[3:0];
        w_entry = r_clut[w_idx];
        w_blend = r_osd_active && (osd_in != 8'd0) && pixel_en_in && (w_idx != 4'd0);
        w_alpha = (w_entry[28:24] > c_ALPHA_MAX) ? c_ALPHA_MAX : w_entry[28:24];
        if (!w_blend) begin
            w_alpha = 5'd0;
        end
        w_inv_a = c_ALPHA_MAX - r_s1_a;
    end

    // CLUT storage: one write per clock; the S1 read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLUT_DEPTH; i++) begin
                r_clut[i] <= '0;
            end
        end else if (clut_wr_en) begin
            r_clut[clut_wr_addr] <= clut_wr_dat;
        end
    end

    // Overlay enable is latched only on a v_sync rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev    <= 1'b0;
            r_osd_active <= 1'b0;
        end else begin
            r_vs_prev <= v_sync_in;
            if (v_sync_in && !r_vs_prev) begin
                r_osd_active <= osd_enable;
            end
        end
    end

    // S1: capture pixel, CLUT colour and effective alpha (0 when not blending).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_py <= '0; r_s1_pu <= '0; r_s1_pv <= '0;
            r_s1_cy <= '0; r_s1_cu <= '0; r_s1_cv <= '0;
            r_s1_a  <= '0;
        end else begin
            r_s1_py <= y_in;
            r_s1_pu <= u_in;
            r_s1_pv <= v_in;
            r_s1_cy <= w_entry[23:16];
            r_s1_cu <= w_entry[15:8];
            r_s1_cv <= w_entry[7:0];
            r_s1_a  <= w_alpha;
        end
    end

    // S2: weighted products; an alpha of 0 leaves the video pixel untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_cy <= '0; r_s2_cu <= '0; r_s2_cv <= '0;
            r_s2_py <= '0; r_s2_pu <= '0; r_s2_pv <= '0;
        end else begin
            r_s2_cy <= 13'(r_s1_cy) * 13'(r_s1_a);
            r_s2_cu <= 13'(r_s1_cu) * 13'(r_s1_a);
            r_s2_cv <= 13'(r_s1_cv) * 13'(r_s1_a);
            r_s2_py <= 13'(r_s1_py) * 13'(w_inv_a);
            r_s2_pu <= 13'(r_s1_pu) * 13'(w_inv_a);
            r_s2_pv <= 13'(r_s1_pv) * 13'(w_inv_a);
        end
    end

    // S3: round and divide by 16 (max 4088, so no saturation); black when inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_out <= c_BLACK_Y;
            r_u_out <= c_BLACK_C;
            r_v_out <= c_BLACK_C;
        end else if (!r_sync[LATENCY-2][0]) begin
            r_y_out <= c_BLACK_Y;
            r_u_out <= c_BLACK_C;
            r_v_out <= c_BLACK_C;
        end else begin
            r_y_out <= 8'((r_s2_cy + r_s2_py + 13'd8) >> 4);
            r_u_out <= 8'((r_s2_cu + r_s2_pu + 13'd8) >> 4);
            r_v_out <= 8'((r_s2_cv + r_s2_pv + 13'd8) >> 4);
        end
    end

    // Sync and active-video delay line matching the pixel pipeline depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_sync[i] <= 3'b000;
            end
        end else begin
            r_sync[0] <= {h_sync_in, v_sync_in, pixel_en_in};
            for (int i = 1; i < LATENCY; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign y_out        = r_y_out;
    assign u_out        = r_u_out;
    assign v_out        = r_v_out;
    assign h_sync_out   = r_sync[LATENCY-1][2];
    assign v_sync_out   = r_sync[LATENCY-1][1];
    assign pixel_en_out = r_sync[LATENCY-1][0];

endmodule
`default_nettype wire

// File: doc/osd_blend.md
OSD_BLEND -- requirements
Module: osd_blend

Interface
REQ-001 The block SHALL have these parameters, one per line: LATENCY, 3, fixed pixel/sync pipeline depth in clocks (not overridable); CLUT_DEPTH, 16, number of OSD colour look-up entries.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 y_in, u_in, v_in  input  8 each  video pixel from mixer stage.
REQ-005 osd_in  input  8  OSD code from mixer; 0 = transparent, bits [3:0] = CLUT index, bits [7:4] ignored.
REQ-006 h_sync_in, v_sync_in, pixel_en_in  input  1 each  syncs and active-video flag from mixer.
REQ-007 osd_enable  input  1  OSD overlay enable request.
REQ-008 clut_wr_en  input  1  CLUT write strobe.
REQ-009 clut_wr_addr  input  4  CLUT entry to write.
REQ-010 clut_wr_dat  input  29  {alpha[28:24], y[23:16], u[15:8], v[7:0]}.
REQ-011 y_out, u_out, v_out  output  8 each  blended pixel to DVI transmitter.
REQ-012 h_sync_out, v_sync_out, pixel_en_out  output  1 each  delayed syncs.

Function
REQ-013 All pixel and sync outputs SHALL appear exactly 3 clocks after the corresponding inputs; syncs and pixel_en SHALL be delayed with no modification.
REQ-014 Pipeline stages: S1 registers inputs and reads the CLUT; S2 forms products; S3 sums, rounds, registers outputs.
REQ-015 CLUT SHALL be 16 entries x 29 bits, one write per clock; a write at clock N SHALL be visible to pixels entering S1 at clock N+1.
REQ-016 Write and S1 read of the same entry in the same clock SHALL return the old entry (read-before-write).
REQ-017 Effective alpha a = min(entry alpha, 16); alpha values 17..31 SHALL clamp to 16.
REQ-018 For each component: out = (clut*a + pix*(16-a) + 8) >> 4, computed in at least 13 bits; result SHALL never exceed 255 and SHALL need no saturation.
REQ-019 Blending SHALL apply only when osd_active=1, osd_in != 0 and pixel_en_in=1; otherwise out = pix unchanged.
REQ-020 Entry 0 SHALL be treated as transparent (a=0) regardless of its stored contents.
REQ-021 When the delayed pixel_en is 0, outputs SHALL be y=16, u=128, v=128 (black).
REQ-022 osd_active SHALL be updated from osd_enable only on a v_sync_in rising edge (0 at clock N-1, 1 at clock N); osd_enable changes mid-frame SHALL have no effect until the next such edge.
REQ-023 osd_active is sampled with each pixel in S1; a pixel in flight SHALL keep the decision made in S1.
REQ-024 Back-to-back pixels SHALL be accepted every clock; the block has no stall or backpressure.

Reset
REQ-025 While rst=1: y_out=16, u_out=128, v_out=128, h_sync_out=0, v_sync_out=0, pixel_en_out=0, osd_active=0, all pipeline registers cleared.
REQ-026 Reset SHALL set every CLUT entry to all zero (transparent).
REQ-027 Reset asserted mid-line SHALL discard in-flight pixels; the first valid output SHALL come 3 clocks after the first input following deassertion.
REQ-028 clut_wr_en SHALL be ignored while rst=1.

Verification
REQ-029 Passthrough: osd_active=0, y/u/v=200/50/90, pixel_en=1 -> outputs 200/50/90 three clocks later, syncs delayed 3.
REQ-030 Full overlay: write entry 5 = {16,235,128,128}, enable, v_sync edge, osd_in=5, pix 16/128/128 -> out 235/128/128.
REQ-031 Half blend: entry 3 alpha 8, y=200; pix y=100 -> y_out = (1600+800+8)>>4 = 150; alpha 31 on entry 3 -> y_out=200.
REQ-032 Enable timing: osd_enable raised mid-frame -> no blending until after the next v_sync rising edge, then blending from the next pixel.
REQ-033 Write collision: write entry 2 and osd_in=2 in the same clock -> that pixel uses the old entry, the next pixel uses the new entry.
REQ-034 Reset mid-line: rst for 1 clock during active video -> outputs 16/128/128, syncs 0 next clock, CLUT transparent, pipeline refills after 3 clocks.
